video_line_buffer_pp: RTL and testbench

Parametrised ping-pong line buffer in the master clock domain. It sits between the VRAM controller or video decoder (the word producer) and the pixel output stage (the pixel consumer). One bank is filled with the next row while the other bank streams the current row as a ready/valid pixel stream. Generalises the single-bank row buffer: configurable pixel width, packing and line length, double buffering, horizontal 2x scaling, and underflow reporting.

---
 rtl/video_line_buffer_pp.sv | 206 ++++++++++++++++++++
 tb/tb_video_line_buffer_pp.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_line_buffer_pp.sv
// Ping-pong line buffer: one bank fills from the word producer while the other
// streams its row as a ready/valid pixel stream with optional 2x horizontal repeat.
module video_line_buffer_pp #(
    parameter int PIXEL_BITS      = 12,
    parameter int PIXELS_PER_WORD = 2,
    parameter int LINE_WORDS      = 320,
    parameter int ADDR_BITS       = 9
) (
    input  logic                                  i_master_clk,
    input  logic                                  i_reset_n,
    input  logic [1:0]                            i_scale_mode,
    input  logic                                  i_line_start,
    output logic                                  o_fetch_start,
    input  logic [ADDR_BITS-1:0]                  i_wr_column,
    input  logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] i_wr_data,
    input  logic                                  i_wr_valid,
    input  logic                                  i_line_swap,
    output logic [PIXEL_BITS-1:0]                 o_pix_data,
    output logic                                  o_pix_valid,
    input  logic                                  i_pix_ready,
    output logic                                  o_read_bank,
    output logic                                  o_underflow,
    input  logic                                  i_clear_underflow
);

    localparam int WORD_BITS = PIXEL_BITS * PIXELS_PER_WORD;
    localparam int NPIX      = LINE_WORDS * PIXELS_PER_WORD;
    localparam int FW        = ADDR_BITS + 1;
    localparam int PCW       = $clog2(NPIX + 1);
    localparam int SW        = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
    localparam logic [FW-1:0]  LW_F     = FW'(LINE_WORDS);
    localparam logic [PCW-1:0] NPIX_C   = PCW'(NPIX);
    localparam logic [PCW-1:0] LAST_PIX = PCW'(NPIX - 1);
    localparam logic [SW-1:0]  SUB_LAST = SW'(PIXELS_PER_WORD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_STREAM} state_t;

    logic [WORD_BITS-1:0] mem [2][LINE_WORDS];
    logic [WORD_BITS-1:0] s1_word_q;

    logic [1:0][FW-1:0]   fill_q, fill_d;
    state_t               state_q, state_d;
    logic                 read_bank_q, read_bank_d;
    logic                 underflow_q, underflow_d;
    logic                 fetch_q, fetch_d;
    logic                 rep_mode_q, rep_mode_d;
    logic                 blank_q, blank_d;
    logic [PCW-1:0]       pix_cnt_q, pix_cnt_d;
    logic [ADDR_BITS-1:0] word_q, word_d;
    logic [SW-1:0]        sub_q, sub_d;
    logic                 rep_q, rep_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [SW-1:0]        s1_sub_q, s1_sub_d;
    logic                 s1_zero_q, s1_zero_d;
    logic                 s1_last_q, s1_last_d;
    logic                 pix_valid_q, pix_valid_d;
    logic [PIXEL_BITS-1:0] pix_data_q, pix_data_d;
    logic                 out_last_q, out_last_d;

    logic wr_bank, wr_ok, uf_event, clr_bank, out_free, s1_free, issue, rd_en;

    always_comb begin
        fill_d      = fill_q;
        state_d     = state_q;
        read_bank_d = read_bank_q;
        rep_mode_d  = rep_mode_q;
        blank_d     = blank_q;
        pix_cnt_d   = pix_cnt_q;
        word_d      = word_q;
        sub_d       = sub_q;
        rep_d       = rep_q;
        s1_valid_d  = s1_valid_q;
        s1_sub_d    = s1_sub_q;
        s1_zero_d   = s1_zero_q;
        s1_last_d   = s1_last_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        out_last_d  = out_last_q;
        fetch_d     = i_line_start;

        wr_bank = ~read_bank_q;
        wr_ok   = i_wr_valid && ({1'b0, i_wr_column} < LW_F);
        if (wr_ok && (fill_q[wr_bank] != LW_F))
            fill_d[wr_bank] = fill_q[wr_bank] + FW'(1);

        // Completeness is judged after this cycle's write, so a write landing with the swap counts.
        uf_event    = i_line_swap && (fill_d[wr_bank] != LW_F);
        clr_bank    = i_line_swap ? read_bank_q : wr_bank;
        if (i_line_start)
            fill_d[clr_bank] = '0;
        underflow_d = (underflow_q && !i_clear_underflow) || uf_event;

        out_free = !pix_valid_q || i_pix_ready;
        s1_free  = !s1_valid_q || out_free;
        issue    = (state_q != ST_IDLE) && (pix_cnt_q != NPIX_C) && s1_free;
        rd_en    = issue && !blank_q;

        if (out_free) begin
            if (s1_valid_q) begin
                pix_valid_d = 1'b1;
                pix_data_d  = s1_zero_q ? '0 : s1_word_q[int'(s1_sub_q)*PIXEL_BITS +: PIXEL_BITS];
                out_last_d  = s1_last_q;
            end else begin
                pix_valid_d = 1'b0;
                pix_data_d  = '0;
                out_last_d  = 1'b0;
            end
            s1_valid_d = 1'b0;
        end

        if (issue) begin
            s1_valid_d = 1'b1;
            s1_sub_d   = sub_q;
            s1_zero_d  = blank_q;
            s1_last_d  = (pix_cnt_q == LAST_PIX);
            pix_cnt_d  = pix_cnt_q + PCW'(1);
            state_d    = ST_STREAM;
            if (rep_mode_q && !rep_q) begin
                rep_d = 1'b1;
            end else begin
                rep_d = 1'b0;
                if (sub_q == SUB_LAST) begin
                    sub_d  = '0;
                    word_d = word_q + ADDR_BITS'(1);
                end else begin
                    sub_d = sub_q + SW'(1);
                end
            end
        end

        if (pix_valid_q && i_pix_ready && out_last_q)
            state_d = ST_IDLE;

        // A swap flushes the pipeline and restarts from pixel 0 of the new bank.
        if (i_line_swap) begin
            read_bank_d = ~read_bank_q;
            rep_mode_d  = (i_scale_mode == 2'd2);
            blank_d     = uf_event || !((i_scale_mode == 2'd1) || (i_scale_mode == 2'd2));
            state_d     = ST_PRIME;
            pix_cnt_d   = '0;
            word_d      = '0;
            sub_d       = '0;
            rep_d       = 1'b0;
            s1_valid_d  = 1'b0;
            pix_valid_d = 1'b0;
            pix_data_d  = '0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge i_master_clk) begin
        if (wr_ok)
            mem[wr_bank][i_wr_column] <= i_wr_data;
        if (rd_en)
            s1_word_q <= mem[read_bank_q][word_q];
    end

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fill_q      <= '0;
            state_q     <= ST_IDLE;
            read_bank_q <= 1'b0;
            underflow_q <= 1'b0;
            fetch_q     <= 1'b0;
            rep_mode_q  <= 1'b0;
            blank_q     <= 1'b0;
            pix_cnt_q   <= '0;
            word_q      <= '0;
            sub_q       <= '0;
            rep_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sub_q    <= '0;
            s1_zero_q   <= 1'b0;
            s1_last_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            state_q     <= state_d;
            read_bank_q <= read_bank_d;
            underflow_q <= underflow_d;
            fetch_q     <= fetch_d;
            rep_mode_q  <= rep_mode_d;
            blank_q     <= blank_d;
            pix_cnt_q   <= pix_cnt_d;
            word_q      <= word_d;
            sub_q       <= sub_d;
            rep_q       <= rep_d;
            s1_valid_q  <= s1_valid_d;
            s1_sub_q    <= s1_sub_d;
            s1_zero_q   <= s1_zero_d;
            s1_last_q   <= s1_last_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign o_fetch_start = fetch_q;
    assign o_pix_data    = pix_data_q;
    assign o_pix_valid   = pix_valid_q;
    assign o_read_bank   = read_bank_q;
    assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_video_line_buffer_pp.sv
// Directed bench for video_line_buffer_pp: expected pixel lines are queued at each
// swap from a reference copy of the written rows and popped as pixels are accepted.
module tb_video_line_buffer_pp;

    localparam int PB   = 12;
    localparam int PPW  = 2;
    localparam int LW   = 320;
    localparam int AB   = 9;
    localparam int WB   = PB * PPW;
    localparam int NPIX = LW * PPW;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic [1:0]    i_scale_mode;
    logic          i_line_start;
    logic          o_fetch_start;
    logic [AB-1:0] i_wr_column;
    logic [WB-1:0] i_wr_data;
    logic          i_wr_valid;
    logic          i_line_swap;
    logic [PB-1:0] o_pix_data;
    logic          o_pix_valid;
    logic          i_pix_ready;
    logic          o_read_bank;
    logic          o_underflow;
    logic          i_clear_underflow;

    always #5 clk = ~clk;

    video_line_buffer_pp #(
        .PIXEL_BITS(PB), .PIXELS_PER_WORD(PPW), .LINE_WORDS(LW), .ADDR_BITS(AB)
    ) dut (
        .i_master_clk(clk), .i_reset_n(i_reset_n), .i_scale_mode(i_scale_mode),
        .i_line_start(i_line_start), .o_fetch_start(o_fetch_start),
        .i_wr_column(i_wr_column), .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid),
        .i_line_swap(i_line_swap), .o_pix_data(o_pix_data), .o_pix_valid(o_pix_valid),
        .i_pix_ready(i_pix_ready), .o_read_bank(o_read_bank), .o_underflow(o_underflow),
        .i_clear_underflow(i_clear_underflow)
    );

    logic [WB-1:0] ref_mem [2][LW];
    logic [PB-1:0] q[$];
    int            checks = 0;
    int            errors = 0;
    int            acc_total = 0;
    logic          stall_prev = 1'b0;
    logic [PB-1:0] stall_data = '0;
    int            fill_idx = 0;
    int            fill_lim = 0;
    int            fill_sel = 0;
    logic          fill_bank = 1'b1;
    logic          rand_ready = 1'b0;
    logic          exp_rb = 1'b0;
    logic          exp_uf = 1'b0;

    function automatic logic [WB-1:0] pat(input int sel, input int k);
        logic [11:0] k12;
        k12 = k[11:0];
        case (sel)
            0:       return {k12, ~k12};
            1:       return {12'hABC ^ k12, 12'h123 + k12};
            default: return {k12 + 12'h007, k12 ^ 12'hF0F};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic bank, input logic [1:0] mode, input logic uf);
        for (int p = 0; p < NPIX; p++) begin
            int w, s;
            logic [WB-1:0] word;
            if (uf || !((mode == 2'd1) || (mode == 2'd2))) begin
                q.push_back('0);
            end else begin
                if (mode == 2'd1) begin
                    w = p / PPW;
                    s = p % PPW;
                end else begin
                    w = p / (2 * PPW);
                    s = (p / 2) % PPW;
                end
                word = ref_mem[bank][w];
                q.push_back(word[s*PB +: PB]);
            end
        end
    endtask

    // Sample at the falling edge, then drive the next cycle's inputs just after the rising edge.
    task automatic step();
        logic [PB-1:0] exp;
        @(negedge clk);
        if (i_reset_n) begin
            if (stall_prev) begin
                chk("stall_valid", o_pix_valid, 1);
                chk("stall_data", o_pix_data, stall_data);
            end
            if (o_pix_valid && i_pix_ready) begin
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL pix_extra observed=%0h expected=none", o_pix_data);
                end
                if (q.size() != 0) begin
                    exp = q.pop_front();
                    chk("pix", o_pix_data, exp);
                    acc_total++;
                end
            end
            stall_prev = o_pix_valid && !i_pix_ready;
            stall_data = o_pix_data;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        if (fill_idx < fill_lim) begin
            i_wr_valid  = 1'b1;
            i_wr_column = AB'(fill_idx);
            i_wr_data   = pat(fill_sel, fill_idx);
            ref_mem[fill_bank][fill_idx] = i_wr_data;
            fill_idx++;
        end else begin
            i_wr_valid = 1'b0;
        end
        if (rand_ready) i_pix_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic fill_row(input int sel, input int lim);
        i_line_start = 1'b1;
        chk("fetch_pre", o_fetch_start, 0);
        step();
        i_line_start = 1'b0;
        chk("fetch_pulse", o_fetch_start, 1);
        fill_bank = ~exp_rb;
        fill_sel  = sel;
        fill_idx  = 0;
        fill_lim  = lim;
        step();
        chk("fetch_end", o_fetch_start, 0);
        while (fill_idx < fill_lim) step();
        step();
    endtask

    task automatic junk_write(input int col);
        i_wr_valid  = 1'b1;
        i_wr_column = AB'(col);
        i_wr_data   = 24'hFFFFFF;
        step();
    endtask

    task automatic swap_line(input logic [1:0] mode, input logic uf, input logic keep_one,
                             input logic ls, input logic clr);
        logic [PB-1:0] keep;
        i_line_swap       = 1'b1;
        i_scale_mode      = mode;
        i_line_start      = ls;
        i_clear_underflow = clr;
        if (keep_one && q.size() != 0) begin
            keep = q[0];
            q.delete();
            q.push_back(keep);
        end else begin
            q.delete();
        end
        exp_rb = ~exp_rb;
        exp_uf = (exp_uf && !clr) || uf;
        push_line(exp_rb, mode, uf);
        step();
        i_line_swap       = 1'b0;
        i_line_start      = 1'b0;
        i_clear_underflow = 1'b0;
        chk("swap_bank", o_read_bank, exp_rb);
        chk("swap_underflow", o_underflow, exp_uf);
        chk("latency_n0", o_pix_valid, 0);
        step();
        chk("latency_n1", o_pix_valid, 0);
        step();
        chk("latency_n2", o_pix_valid, 1);
    endtask

    task automatic drain(input int exp_n);
        int n;
        n = 0;
        while ((q.size() != 0 || o_pix_valid) && n < 3000) begin
            step();
            n++;
        end
        if (exp_n >= 0) chk("line_cycles", n, exp_n);
        else            chk("line_drained", q.size(), 0);
        chk("end_valid", o_pix_valid, 0);
        chk("end_data", o_pix_data, 0);
    endtask

    task automatic wait_pixels(input int target);
        int base, n;
        base = acc_total;
        n = 0;
        while ((acc_total - base) < target && n < 2000) begin
            step();
            n++;
        end
        chk("reach_pixel", acc_total - base, target);
    endtask

    initial begin
        i_reset_n = 1'b0; i_scale_mode = 2'd0; i_line_start = 1'b0; i_wr_column = '0;
        i_wr_data = '0; i_wr_valid = 1'b0; i_line_swap = 1'b0; i_pix_ready = 1'b1;
        i_clear_underflow = 1'b0;
        step(); step();
        chk("rst_valid", o_pix_valid, 0);
        chk("rst_data", o_pix_data, 0);
        chk("rst_fetch", o_fetch_start, 0);
        chk("rst_underflow", o_underflow, 0);
        chk("rst_bank", o_read_bank, 0);
        i_reset_n = 1'b1;
        step();

        // Fill bank 1, then display it while bank 0 fills; line_start rides on the swap.
        fill_row(0, LW);
        fill_bank = 1'b0; fill_sel = 1; fill_idx = 0; fill_lim = LW;
        swap_line(2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(640);

        // Bank 0 under random backpressure.
        rand_ready = 1'b1;
        swap_line(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(-1);
        rand_ready = 1'b0;
        i_pix_ready = 1'b1;

        // Bank 1 again (must be intact), abandoned at pixel 300 for 2x of bank 0.
        swap_line(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_pixels(300);
        swap_line(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("x2_first", o_pix_data, 12'h123);
        drain(640);

        swap_line(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(640);

        // Last word lands with the swap; out-of-range columns must be ignored.
        fill_row(2, LW - 1);
        junk_write(320);
        junk_write(511);
        i_wr_valid = 1'b1; i_wr_column = AB'(LW - 1); i_wr_data = pat(2, LW - 1);
        ref_mem[fill_bank][LW-1] = i_wr_data;
        swap_line(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(640);

        fill_row(0, LW - 1);
        junk_write(320);
        junk_write(511);
        swap_line(2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        drain(640);

        // Reset in the middle of a line.
        swap_line(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_pixels(100);
        i_reset_n = 1'b0;
        #1;
        chk("midrst_valid", o_pix_valid, 0);
        chk("midrst_data", o_pix_data, 0);
        chk("midrst_bank", o_read_bank, 0);
        chk("midrst_underflow", o_underflow, 0);
        q.delete();
        exp_rb = 1'b0;
        exp_uf = 1'b0;
        step(); step();
        i_reset_n = 1'b1;
        step();
        swap_line(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drain(640);

        i_clear_underflow = 1'b1;
        step();
        i_clear_underflow = 1'b0;
        chk("underflow_cleared", o_underflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
